// File: rtl/id_pair_packer.sv
// Packs narrow ID-pair stream beats into wide output words, flushing partial
// words on tlast with byte-accurate tkeep, and reports pairs per packet.
module id_pair_packer #(
    parameter int VEC_ID_WIDTH   = 8,
    parameter int PAIR_WIDTH     = 2 * VEC_ID_WIDTH,
    parameter int OUT_WIDTH      = 128,
    parameter int PAIRS_PER_BEAT = OUT_WIDTH / PAIR_WIDTH,
    parameter int SLOT_CNT_WIDTH = (PAIRS_PER_BEAT > 1) ? $clog2(PAIRS_PER_BEAT) : 1,
    parameter int PCNT_WIDTH     = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rstn,

    input  logic [PAIR_WIDTH-1:0]   S_AXIS_ID_PAIR_tdata,
    input  logic                    S_AXIS_ID_PAIR_tvalid,
    input  logic                    S_AXIS_ID_PAIR_tlast,
    output logic                    S_AXIS_ID_PAIR_tready,

    output logic [OUT_WIDTH-1:0]    M_AXIS_OUT_tdata,
    output logic [OUT_WIDTH/8-1:0]  M_AXIS_OUT_tkeep,
    output logic                    M_AXIS_OUT_tvalid,
    output logic                    M_AXIS_OUT_tlast,
    input  logic                    M_AXIS_OUT_tready,

    output logic [PCNT_WIDTH-1:0]   o_PairCount,
    output logic                    o_Done
);

    localparam int KEEP_WIDTH     = OUT_WIDTH / 8;
    localparam int BYTES_PER_PAIR = PAIR_WIDTH / 8;
    localparam logic [SLOT_CNT_WIDTH-1:0] LAST_SLOT = SLOT_CNT_WIDTH'(PAIRS_PER_BEAT - 1);
    localparam logic [PCNT_WIDTH-1:0]     PCNT_MAX  = '1;

    // accumulator side
    logic [OUT_WIDTH-1:0]      acc_q, acc_d;
    logic [KEEP_WIDTH-1:0]     acc_keep_q, acc_keep_d;
    logic                      acc_last_q, acc_last_d;
    logic [SLOT_CNT_WIDTH-1:0] sc_q, sc_d;
    logic                      ap_q, ap_d;

    // output register side
    logic [OUT_WIDTH-1:0]      out_q, out_d;
    logic [KEEP_WIDTH-1:0]     out_keep_q, out_keep_d;
    logic                      out_last_q, out_last_d;
    logic                      ov_q, ov_d;

    logic                      re_q, re_d;
    logic [PCNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [PCNT_WIDTH-1:0]     pcnt_q, pcnt_d;
    logic                      done_q, done_d;

    logic                      s_ready;
    logic                      accept;
    logic                      out_free;
    logic                      close;
    logic [PCNT_WIDTH-1:0]     cnt_inc;
    logic [OUT_WIDTH-1:0]      acc_ins;
    logic [KEEP_WIDTH-1:0]     keep_ins;

    assign s_ready  = re_q & ~ap_q;
    assign accept   = S_AXIS_ID_PAIR_tvalid & s_ready;
    assign out_free = ~ov_q | M_AXIS_OUT_tready;
    assign close    = accept & ((sc_q == LAST_SLOT) | S_AXIS_ID_PAIR_tlast);
    assign cnt_inc  = (cnt_q == PCNT_MAX) ? cnt_q : cnt_q + PCNT_WIDTH'(1);

    // Accumulator with the incoming pair merged into slot sc.
    always_comb begin
        acc_ins  = acc_q;
        keep_ins = acc_keep_q;
        for (int i = 0; i < PAIRS_PER_BEAT; i++) begin
            if (sc_q == SLOT_CNT_WIDTH'(i)) begin
                acc_ins[i*PAIR_WIDTH +: PAIR_WIDTH]          = S_AXIS_ID_PAIR_tdata;
                keep_ins[i*BYTES_PER_PAIR +: BYTES_PER_PAIR] = '1;
            end
        end
    end

    always_comb begin
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        acc_last_d = acc_last_q;
        sc_d       = sc_q;
        ap_d       = ap_q;
        out_d      = out_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        ov_d       = ov_q;
        re_d       = 1'b1;

        if (ov_q && M_AXIS_OUT_tready) begin
            ov_d = 1'b0;
        end

        if (ap_q && out_free) begin
            out_d      = acc_q;
            out_keep_d = acc_keep_q;
            out_last_d = acc_last_q;
            ov_d       = 1'b1;
            ap_d       = 1'b0;
            sc_d       = '0;
            acc_d      = '0;
            acc_keep_d = '0;
            acc_last_d = 1'b0;
        end else if (close && out_free) begin
            out_d      = acc_ins;
            out_keep_d = keep_ins;
            out_last_d = S_AXIS_ID_PAIR_tlast;
            ov_d       = 1'b1;
            sc_d       = '0;
            acc_d      = '0;
            acc_keep_d = '0;
            acc_last_d = 1'b0;
        end else if (close) begin
            // OUT still occupied: park the finished word in ACC and stall input.
            acc_d      = acc_ins;
            acc_keep_d = keep_ins;
            acc_last_d = S_AXIS_ID_PAIR_tlast;
            ap_d       = 1'b1;
        end else if (accept) begin
            acc_d      = acc_ins;
            acc_keep_d = keep_ins;
            sc_d       = sc_q + SLOT_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        pcnt_d = pcnt_q;
        done_d = 1'b0;
        if (accept) begin
            if (S_AXIS_ID_PAIR_tlast) begin
                pcnt_d = cnt_inc;
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_inc;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            acc_q      <= '0;
            acc_keep_q <= '0;
            acc_last_q <= 1'b0;
            sc_q       <= '0;
            ap_q       <= 1'b0;
            out_q      <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            ov_q       <= 1'b0;
            re_q       <= 1'b0;
            cnt_q      <= '0;
            pcnt_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            acc_last_q <= acc_last_d;
            sc_q       <= sc_d;
            ap_q       <= ap_d;
            out_q      <= out_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            ov_q       <= ov_d;
            re_q       <= re_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            done_q     <= done_d;
        end
    end

    assign S_AXIS_ID_PAIR_tready = s_ready;
    assign M_AXIS_OUT_tdata      = out_q;
    assign M_AXIS_OUT_tkeep      = out_keep_q;
    assign M_AXIS_OUT_tvalid     = ov_q;
    assign M_AXIS_OUT_tlast      = out_last_q;
    assign o_PairCount           = pcnt_q;
    assign o_Done                = done_q;

endmodule

// File: tb/tb_id_pair_packer.sv
// Bench for id_pair_packer: directed packets plus a long random run, all
// checked against a queue-based packing model.
module tb_id_pair_packer;

    localparam int PPB = 8;

    logic         clk = 1'b0;
    logic         ap_rstn;
    logic [15:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [31:0]  o_PairCount;
    logic         o_Done;

    always #5 clk = ~clk;

    id_pair_packer dut (
        .ap_clk                (clk),
        .ap_rstn               (ap_rstn),
        .S_AXIS_ID_PAIR_tdata  (s_tdata),
        .S_AXIS_ID_PAIR_tvalid (s_tvalid),
        .S_AXIS_ID_PAIR_tlast  (s_tlast),
        .S_AXIS_ID_PAIR_tready (s_tready),
        .M_AXIS_OUT_tdata      (m_tdata),
        .M_AXIS_OUT_tkeep      (m_tkeep),
        .M_AXIS_OUT_tvalid     (m_tvalid),
        .M_AXIS_OUT_tlast      (m_tlast),
        .M_AXIS_OUT_tready     (m_tready),
        .o_PairCount           (o_PairCount),
        .o_Done                (o_Done)
    );

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    int vectors     = 0;
    int miscompares = 0;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [15:0] cur_q[$];
    int          done_q[$];
    int          pkt_cnt   = 0;
    bit          done_pend = 0;
    int          done_exp  = 0;
    bit          prev_stall = 0;
    beat_t       prev_beat;
    bit          rand_ready = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and compare process, evaluated mid-cycle when the
    // handshakes for the coming edge are settled.
    always @(negedge clk) begin
        beat_t e;
        beat_t w;
        if (!ap_rstn) begin
            exp_q.delete();
            cur_q.delete();
            pkt_cnt    = 0;
            done_pend  = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 128'(m_tvalid), 128'd1);
                check("hold_data", m_tdata, prev_beat.d);
                check("hold_keep", 128'(m_tkeep), 128'(prev_beat.k));
                check("hold_last", 128'(m_tlast), 128'(prev_beat.l));
            end
            check("done", 128'(o_Done), 128'(done_pend));
            if (done_pend) begin
                check("pair_count", 128'(o_PairCount), 128'(done_exp));
                done_q.push_back(int'(o_PairCount));
            end
            if (m_tvalid && m_tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got data %h keep %h, expected no beat", m_tdata, m_tkeep);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_tdata, e.d);
                    check("beat_keep", 128'(m_tkeep), 128'(e.k));
                    check("beat_last", 128'(m_tlast), 128'(e.l));
                end
                w.d = m_tdata; w.k = m_tkeep; w.l = m_tlast;
                obs_q.push_back(w);
            end
            prev_stall  = m_tvalid && !m_tready;
            prev_beat.d = m_tdata; prev_beat.k = m_tkeep; prev_beat.l = m_tlast;

            done_pend = 0;
            if (s_tvalid && s_tready) begin
                cur_q.push_back(s_tdata);
                pkt_cnt++;
                if (s_tlast) begin
                    done_pend = 1;
                    done_exp  = pkt_cnt;
                    pkt_cnt   = 0;
                end
                if (cur_q.size() == PPB || s_tlast) begin
                    w.d = '0; w.k = '0; w.l = s_tlast;
                    for (int i = 0; i < cur_q.size(); i++) begin
                        w.d = w.d | (128'(cur_q[i]) << (16 * i));
                        w.k = w.k | (16'h3 << (2 * i));
                    end
                    exp_q.push_back(w);
                    cur_q.delete();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
        end
    end

    // Present one pair and hold it until accepted; reports cycles taken.
    task automatic push(input logic [15:0] d, input bit l, output int cycles);
        bit acc;
        cycles   = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            cycles++;
        end while (!acc && cycles < 2000);
        if (!acc) begin
            miscompares++;
            $display("FAIL push_timeout: pair %h not accepted after %0d cycles, required acceptance", d, cycles);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        check("drain_done", 128'(exp_q.size() != 0 || m_tvalid), 128'd0);
        idle(2);
    endtask

    task automatic check_beat(input string name, input int idx, input logic [15:0] k, input bit l);
        if (idx < obs_q.size()) begin
            check({name, "_keep"}, 128'(obs_q[idx].k), 128'(k));
            check({name, "_last"}, 128'(obs_q[idx].l), 128'(l));
        end else begin
            check({name, "_present"}, 128'(obs_q.size()), 128'(idx + 1));
        end
    endtask

    initial begin
        int cyc;
        int n;
        int sent;
        ap_rstn  = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        #2 ap_rstn = 1'b0;
        #2;
        check("rst_tdata", m_tdata, 128'd0);
        check("rst_tkeep", 128'(m_tkeep), 128'd0);
        check("rst_tvalid", 128'(m_tvalid), 128'd0);
        check("rst_tlast", 128'(m_tlast), 128'd0);
        check("rst_s_tready", 128'(s_tready), 128'd0);
        check("rst_pcount", 128'(o_PairCount), 128'd0);
        check("rst_done", 128'(o_Done), 128'd0);
        repeat (3) @(posedge clk);
        #1 ap_rstn = 1'b1;
        check("tready_before_re", 128'(s_tready), 128'd0);
        idle(1);
        check("tready_after_re", 128'(s_tready), 128'd1);

        // 1: full word
        m_tready = 1'b1;
        obs_q.delete();
        for (int i = 1; i <= 8; i++) push(16'(i), i == 8, cyc);
        check("t1_latency_valid", 128'(m_tvalid), 128'd1);
        check("t1_done_now", 128'(o_Done), 128'd1);
        check("t1_pcount", 128'(o_PairCount), 128'd8);
        drain();
        check("t1_beats", 128'(obs_q.size()), 128'd1);
        if (obs_q.size() > 0)
            check("t1_data", obs_q[0].d, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check_beat("t1", 0, 16'hFFFF, 1'b1);

        // 2: partial flush
        obs_q.delete();
        push(16'hAA01, 0, cyc);
        push(16'hAA02, 0, cyc);
        push(16'hAA03, 1, cyc);
        drain();
        check("t2_beats", 128'(obs_q.size()), 128'd1);
        if (obs_q.size() > 0)
            check("t2_data", obs_q[0].d, 128'h0000_0000_0000_0000_0000_AA03_AA02_AA01);
        check_beat("t2", 0, 16'h003F, 1'b1);
        check("t2_pcount", 128'(o_PairCount), 128'd3);

        // 3: backpressure
        obs_q.delete();
        m_tready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            push(16'h3000 + 16'(i), 0, cyc);
            check("t3_no_early_stall", 128'(cyc), 128'd1);
        end
        for (int i = 0; i < 3; i++) begin
            check("t3_stalled", 128'(s_tready), 128'd0);
            idle(1);
        end
        m_tready = 1'b1;
        for (int i = 17; i <= 20; i++) push(16'h3000 + 16'(i), i == 20, cyc);
        drain();
        check("t3_beats", 128'(obs_q.size()), 128'd3);
        check_beat("t3_b0", 0, 16'hFFFF, 1'b0);
        check_beat("t3_b1", 1, 16'hFFFF, 1'b0);
        check_beat("t3_b2", 2, 16'h00FF, 1'b1);

        // 4: back-to-back packets, continuous valid
        obs_q.delete();
        done_q.delete();
        push(16'h4000, 1, cyc);
        check("t4_no_stall", 128'(cyc), 128'd1);
        for (int i = 1; i <= 9; i++) begin
            push(16'h4000 + 16'(i), i == 9, cyc);
            check("t4_no_stall", 128'(cyc), 128'd1);
        end
        drain();
        check("t4_beats", 128'(obs_q.size()), 128'd3);
        check_beat("t4_b0", 0, 16'h0003, 1'b1);
        check_beat("t4_b1", 1, 16'hFFFF, 1'b0);
        check_beat("t4_b2", 2, 16'h0003, 1'b1);
        check("t4_dones", 128'(done_q.size()), 128'd2);
        if (done_q.size() == 2) begin
            check("t4_pcount_a", 128'(done_q[0]), 128'd1);
            check("t4_pcount_b", 128'(done_q[1]), 128'd9);
        end

        // 5: reset mid-packet
        obs_q.delete();
        for (int i = 1; i <= 5; i++) push(16'h5100 + 16'(i), 0, cyc);
        @(posedge clk); #3 ap_rstn = 1'b0;
        #1;
        check("t5_tdata", m_tdata, 128'd0);
        check("t5_tkeep", 128'(m_tkeep), 128'd0);
        check("t5_tvalid", 128'(m_tvalid), 128'd0);
        check("t5_tlast", 128'(m_tlast), 128'd0);
        check("t5_s_tready", 128'(s_tready), 128'd0);
        check("t5_pcount", 128'(o_PairCount), 128'd0);
        check("t5_done", 128'(o_Done), 128'd0);
        @(posedge clk); #1 ap_rstn = 1'b1;
        check("t5_tready_before", 128'(s_tready), 128'd0);
        idle(1);
        check("t5_tready_after", 128'(s_tready), 128'd1);
        push(16'h5501, 0, cyc);
        push(16'h5502, 1, cyc);
        drain();
        check("t5_beats", 128'(obs_q.size()), 128'd1);
        if (obs_q.size() > 0) check("t5_data", obs_q[0].d, 128'h5502_5501);
        check_beat("t5", 0, 16'h000F, 1'b1);
        check("t5_pcount2", 128'(o_PairCount), 128'd2);

        // 6: random packets with random valid/ready
        rand_ready = 1;
        sent = 0;
        while (sent < 1000) begin
            n = $urandom_range(1, 20);
            if (sent + n > 1000) n = 1000 - sent;
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, 2));
                push(16'($urandom), i == n - 1, cyc);
            end
            sent += n;
        end
        rand_ready = 0;
        m_tready = 1'b1;
        drain();
        check("t6_model_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
